serial_add_ctrl: RTL and testbench

SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

---
 rtl/serial_add_ctrl_pkg.sv | 20 ++
 rtl/half_adder.sv | 18 +
 rtl/serial_add_ctrl.sv | 106 ++++++++++
 tb/tb_serial_add_ctrl.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/serial_add_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : serial_add_ctrl_pkg
// Purpose  : Shared state encodings and default width for the bit-serial
//            adder controller.
// Revision : 1.0 - initial release
// ============================================================================
package serial_add_ctrl_pkg;

  localparam int WIDTH_DEFAULT = 8;

  // 2'b11 is deliberately unused; the FSM steers it back to IDLE.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage
`default_nettype wire

// File: rtl/half_adder.sv
`default_nettype none
// ============================================================================
// Module   : half_adder
// Purpose  : One-bit half adder; two of these plus an OR form the full adder.
// Revision : 1.0 - initial release
// ============================================================================
module half_adder (
  input  logic x,
  input  logic y,
  output logic s,
  output logic c
);

  assign s = x ^ y;
  assign c = x & y;

endmodule
`default_nettype wire

// File: rtl/serial_add_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : serial_add_ctrl
// Purpose  : Adds two WIDTH-bit operands LSB first, one bit per clock, through
//            a single full-adder cell. busy marks the RUN phase, done pulses
//            for one cycle when sum/carry_out have been refreshed.
// Revision : 1.0 - initial release
// ============================================================================
module serial_add_ctrl
  import serial_add_ctrl_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

  state_t           state, next_state;
  logic [WIDTH-1:0] a_sr, b_sr;
  logic [WIDTH-2:0] work;        // sum bits gathered so far, newest at MSB
  logic [WIDTH-1:0] work_next;   // work with the current cell output shifted in
  logic [CW-1:0]    idx;
  logic             carry;
  logic             accept;
  logic             last_bit;

  // Full-adder cell: two half adders, carries merged by an OR gate.
  logic ha1_s, ha1_c, fa_s, ha2_c, fa_c;

  half_adder u_ha1 (.x(a_sr[0]), .y(b_sr[0]), .s(ha1_s), .c(ha1_c));
  half_adder u_ha2 (.x(ha1_s),   .y(carry),   .s(fa_s),  .c(ha2_c));

  assign fa_c      = ha1_c | ha2_c;
  assign work_next = {fa_s, work};
  assign accept    = start && ((state == IDLE) || (state == DONE));
  assign last_bit  = (state == RUN) && (idx == LAST_IDX);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state logic; DONE behaves like IDLE towards a new start.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    next_state = start ? RUN : IDLE;
      RUN:     next_state = last_bit ? DONE : RUN;
      DONE:    next_state = start ? RUN : IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Registered status flags, decoded from the state being entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= (next_state == RUN);
      done <= (next_state == DONE);
    end
  end

  // Operand capture, serial shifting and result load on the final bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr      <= '0;
      b_sr      <= '0;
      work      <= '0;
      idx       <= '0;
      carry     <= 1'b0;
      sum       <= '0;
      carry_out <= 1'b0;
    end else if (accept) begin
      a_sr  <= a;
      b_sr  <= b;
      work  <= '0;
      idx   <= '0;
      carry <= 1'b0;
    end else if (state == RUN) begin
      a_sr  <= a_sr >> 1;
      b_sr  <= b_sr >> 1;
      work  <= work_next[WIDTH-1:1];
      carry <= fa_c;
      idx   <= idx + CW'(1);
      if (last_bit) begin
        sum       <= work_next;
        carry_out <= fa_c;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_serial_add_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_add_ctrl
// Purpose  : Self-checking bench: an 8-bit instance for directed and random
//            operations, a 4-bit instance swept over every operand pair.
//            Expected results come from plain integer addition.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_add_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start8, start4;
  logic [7:0] a8, b8, sum8;
  logic [3:0] a4, b4, sum4;
  logic       busy8, done8, co8;
  logic       busy4, done4, co4;
  int         total = 0;
  int         bad   = 0;

  always #5 clk = ~clk;

  serial_add_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .sum(sum8), .carry_out(co8)
  );

  serial_add_ctrl #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .sum(sum4), .carry_out(co4)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Accept edge E0 for the 8-bit instance.
  task automatic start_op(input logic [7:0] x, input logic [7:0] y, input string tag);
    start8 = 1'b1; a8 = x; b8 = y;
    tick;
    chk({tag, "_accept"}, {busy8, done8}, 2'b10);
  endtask

  // Edges E1..E8; optionally keeps start high and scrambles a/b mid-run.
  task automatic finish_op(input logic [7:0] x, input logic [7:0] y,
                           input bit hold, input bit scramble, input string tag);
    logic [8:0] expv;
    expv = {1'b0, x} + {1'b0, y};
    if (!hold) start8 = 1'b0;
    for (int i = 1; i < 8; i++) begin
      if (scramble && i == 3) begin
        a8 = 8'h11; b8 = 8'h22;
      end else if (scramble) begin
        a8 = 8'($urandom); b8 = 8'($urandom);
      end
      tick;
      chk({tag, "_run"}, {busy8, done8}, 2'b10);
    end
    tick;
    chk({tag, "_done"}, {busy8, done8}, 2'b01);
    chk({tag, "_result"}, {co8, sum8}, expv);
  endtask

  // Return to IDLE after a done pulse and confirm the pulse lasted one cycle.
  task automatic idle_after(input string tag);
    start8 = 1'b0;
    tick;
    chk({tag, "_idle"}, {busy8, done8}, 2'b00);
  endtask

  initial begin
    logic [7:0] rx, ry;
    logic [4:0] exp4;
    int         n;
    bit         hold;

    rst_n = 1'b0; start8 = 1'b0; start4 = 1'b0;
    a8 = '0; b8 = '0; a4 = '0; b4 = '0;
    #12;
    chk("reset8", {busy8, done8, co8, sum8}, 11'd0);
    chk("reset4", {busy4, done4, co4, sum4}, 7'd0);
    rst_n = 1'b1;
    tick;
    chk("idle8", {busy8, done8}, 2'b00);

    // Directed 8-bit cases.
    start_op(8'hA5, 8'h5A, "a5_5a"); finish_op(8'hA5, 8'h5A, 0, 0, "a5_5a"); idle_after("a5_5a");
    start_op(8'hFF, 8'h01, "ff_01"); finish_op(8'hFF, 8'h01, 0, 0, "ff_01"); idle_after("ff_01");
    start_op(8'h00, 8'h00, "00_00"); finish_op(8'h00, 8'h00, 0, 0, "00_00"); idle_after("00_00");

    // start held and operands changed mid-run: single done, captured values.
    start_op(8'h37, 8'hC4, "hold"); finish_op(8'h37, 8'hC4, 1, 1, "hold"); idle_after("hold");

    // Back-to-back: start during DONE with 0x80 + 0x80.
    start_op(8'h12, 8'h34, "b2b1"); finish_op(8'h12, 8'h34, 0, 0, "b2b1");
    start_op(8'h80, 8'h80, "b2b2"); finish_op(8'h80, 8'h80, 0, 0, "b2b2"); idle_after("b2b2");

    // Reset mid-run after four bits have been processed.
    start_op(8'h9C, 8'h71, "abort");
    start8 = 1'b0;
    for (int i = 0; i < 4; i++) tick;
    rst_n = 1'b0;
    #1;
    chk("abort_outputs", {busy8, done8, co8, sum8}, 11'd0);
    start8 = 1'b1; a8 = 8'hEE; b8 = 8'hEE;
    tick;
    tick;
    chk("abort_held", {busy8, done8, co8, sum8}, 11'd0);
    #3 rst_n = 1'b1;
    start8 = 1'b0;
    tick;
    chk("abort_nodone", {busy8, done8}, 2'b00);
    start_op(8'h3C, 8'h0F, "post_rst"); finish_op(8'h3C, 8'h0F, 0, 0, "post_rst"); idle_after("post_rst");

    // Randomized 8-bit operations against integer addition.
    for (int k = 0; k < 16; k++) begin
      rx = 8'($urandom); ry = 8'($urandom); hold = 1'($urandom);
      start_op(rx, ry, "rand");
      finish_op(rx, ry, hold, 1, "rand");
      idle_after("rand");
    end

    // 4-bit instance: every operand pair, latency measured with a bounded wait.
    for (int x = 0; x < 16; x++) begin
      for (int y = 0; y < 16; y++) begin
        start4 = 1'b1; a4 = 4'(x); b4 = 4'(y);
        tick;
        start4 = 1'b0; a4 = 4'($urandom); b4 = 4'($urandom);
        n = 0;
        while (!done4 && n < 10) begin
          tick;
          n++;
        end
        exp4 = 5'(x + y);
        chk("w4_latency", 64'(n), 64'd4);
        chk("w4_result", {co4, sum4}, exp4);
        tick;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
